// File: rtl/dc_derr_sched.sv
// dc_derr_sched: request sequencer for the chroma DC error-diffusion quantizer.
// Launches the DC-correction datapath once per macroblock. Serves its top-error
// reads from a per-column line buffer and its left error from a register.
// Folds the returned diffusion errors into the next left/top words and hands
// the quantized levels downstream through a one-entry valid/ready buffer.
// Optional build macro DC_DERR_SCHED_STATS_EN adds stat_mb_cnt / stat_stall_cnt.
module dc_derr_sched #(
   parameter int MAX_MB_W = 1024,
   parameter int ADDR_W   = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [9:0]   req_x,
   input  logic [9:0]   req_y,
   input  logic [127:0] req_in,
   input  logic [15:0]  req_q,
   input  logic [15:0]  req_iq,
   input  logic [31:0]  req_bias,
   input  logic [31:0]  req_zthresh,
   output logic         dc_start,
   output logic [9:0]   dc_x,
   output logic [9:0]   dc_y,
   output logic [127:0] dc_in,
   output logic [15:0]  dc_q,
   output logic [15:0]  dc_iq,
   output logic [31:0]  dc_bias,
   output logic [31:0]  dc_zthresh,
   output logic [31:0]  dc_left_derr,
   output logic [31:0]  dc_top_derr,
   input  logic         dc_top_derr_en,
   input  logic [9:0]   dc_top_derr_addr,
   input  logic [127:0] dc_out,
   input  logic [47:0]  dc_derr,
   input  logic         dc_done,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [127:0] res_out,
   output logic [9:0]   res_x,
   output logic [9:0]   res_y,
   output logic         busy
`ifdef DC_DERR_SCHED_STATS_EN
   ,
   output logic [31:0]  stat_mb_cnt,
   output logic [31:0]  stat_stall_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_RUN    = 2'd2,
      S_UPD    = 2'd3
   } state_t;

   state_t       state;
   logic [47:0]  derr_q;
   logic [31:0]  u_err;
   logic [31:0]  v_err;
   logic [31:0]  left_nxt;
   logic [31:0]  top_nxt;
   logic         accept;

   logic [31:0]  mem [MAX_MB_W];

   // Per-channel split of {e2,e1,e0} into {T1,T0,L1,L0}.
   // L1 = (3*e2)>>>2 evaluated at 10 bits so 3*e2 cannot overflow; T1 wraps.
   function automatic logic [31:0] chan_err(input logic [23:0] e);
      logic signed [9:0] e2x;
      logic signed [9:0] p3;
      logic signed [9:0] l1x;
      logic [7:0]        l1;
      logic [7:0]        t1;
      e2x = {{2{e[23]}}, e[23:16]};
      p3  = e2x + (e2x <<< 1);
      l1x = p3 >>> 2;
      l1  = l1x[7:0];
      t1  = e[23:16] - l1;
      return {t1, e[15:8], l1, e[7:0]};
   endfunction

   assign req_ready = (state == S_IDLE) && !res_valid;
   assign accept    = req_valid && req_ready;

   // Next left/top error words derived from the captured diffusion errors.
   always_comb begin
      u_err    = chan_err(derr_q[23:0]);
      v_err    = chan_err(derr_q[47:24]);
      left_nxt = {v_err[15:8], v_err[7:0], u_err[15:8], u_err[7:0]};
      top_nxt  = {v_err[31:24], v_err[23:16], u_err[31:24], u_err[23:16]};
   end

   // Sequencer FSM with registered launch, result and left-error outputs.
   // Results load on the dc_done edge so res_valid coincides with S_UPD;
   // the error words are written from the captured copy during S_UPD.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         dc_start     <= 1'b0;
         busy         <= 1'b0;
         dc_x         <= '0;
         dc_y         <= '0;
         dc_in        <= '0;
         dc_q         <= '0;
         dc_iq        <= '0;
         dc_bias      <= '0;
         dc_zthresh   <= '0;
         dc_left_derr <= '0;
         derr_q       <= '0;
         res_valid    <= 1'b0;
         res_out      <= '0;
         res_x        <= '0;
         res_y        <= '0;
      end else begin
         dc_start <= 1'b0;
         if (res_valid && res_ready) begin
            res_valid <= 1'b0;
         end
         case (state)
            S_IDLE: begin
               if (accept) begin
                  dc_x       <= req_x;
                  dc_y       <= req_y;
                  dc_in      <= req_in;
                  dc_q       <= req_q;
                  dc_iq      <= req_iq;
                  dc_bias    <= req_bias;
                  dc_zthresh <= req_zthresh;
                  dc_start   <= 1'b1;
                  busy       <= 1'b1;
                  state      <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               state <= S_RUN;
            end
            S_RUN: begin
               if (dc_done) begin
                  derr_q    <= dc_derr;
                  res_out   <= dc_out;
                  res_x     <= dc_x;
                  res_y     <= dc_y;
                  res_valid <= 1'b1;
                  state     <= S_UPD;
               end
            end
            S_UPD: begin
               dc_left_derr <= left_nxt;
               busy         <= 1'b0;
               state        <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Line-buffer write of the next top-error word for this column.
   always_ff @(posedge clk) begin
      if (state == S_UPD) begin
         mem[dc_x[ADDR_W-1:0]] <= top_nxt;
      end
   end

   // Line-buffer read port; the read happens regardless of state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dc_top_derr <= '0;
      end else if (dc_top_derr_en) begin
         dc_top_derr <= mem[dc_top_derr_addr[ADDR_W-1:0]];
      end
   end

`ifdef DC_DERR_SCHED_STATS_EN
   // Accepted-request and result-stall counters, wrapping at 2^32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_mb_cnt    <= '0;
         stat_stall_cnt <= '0;
      end else begin
         if (accept) begin
            stat_mb_cnt <= stat_mb_cnt + 32'd1;
         end
         if (res_valid && !res_ready) begin
            stat_stall_cnt <= stat_stall_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dc_derr_sched.sv
// Directed self-checking bench for dc_derr_sched. The bench plays the
// DC-correction datapath: it issues the top-error read strobe and the
// dc_done pulse at fixed cycles after launch. Expected values are hand-computed.
module tb_dc_derr_sched;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid;
   logic         req_ready;
   logic [9:0]   req_x;
   logic [9:0]   req_y;
   logic [127:0] req_in;
   logic [15:0]  req_q;
   logic [15:0]  req_iq;
   logic [31:0]  req_bias;
   logic [31:0]  req_zthresh;
   logic         dc_start;
   logic [9:0]   dc_x;
   logic [9:0]   dc_y;
   logic [127:0] dc_in;
   logic [15:0]  dc_q;
   logic [15:0]  dc_iq;
   logic [31:0]  dc_bias;
   logic [31:0]  dc_zthresh;
   logic [31:0]  dc_left_derr;
   logic [31:0]  dc_top_derr;
   logic         dc_top_derr_en;
   logic [9:0]   dc_top_derr_addr;
   logic [127:0] dc_out;
   logic [47:0]  dc_derr;
   logic         dc_done;
   logic         res_valid;
   logic         res_ready;
   logic [127:0] res_out;
   logic [9:0]   res_x;
   logic [9:0]   res_y;
   logic         busy;
`ifdef DC_DERR_SCHED_STATS_EN
   logic [31:0]  stat_mb_cnt;
   logic [31:0]  stat_stall_cnt;
`endif

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;

   dc_derr_sched #(.MAX_MB_W(1024), .ADDR_W(10)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_x(req_x), .req_y(req_y), .req_in(req_in),
      .req_q(req_q), .req_iq(req_iq), .req_bias(req_bias), .req_zthresh(req_zthresh),
      .dc_start(dc_start), .dc_x(dc_x), .dc_y(dc_y), .dc_in(dc_in),
      .dc_q(dc_q), .dc_iq(dc_iq), .dc_bias(dc_bias), .dc_zthresh(dc_zthresh),
      .dc_left_derr(dc_left_derr), .dc_top_derr(dc_top_derr),
      .dc_top_derr_en(dc_top_derr_en), .dc_top_derr_addr(dc_top_derr_addr),
      .dc_out(dc_out), .dc_derr(dc_derr), .dc_done(dc_done),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_out(res_out), .res_x(res_x), .res_y(res_y),
      .busy(busy)
`ifdef DC_DERR_SCHED_STATS_EN
      , .stat_mb_cnt(stat_mb_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One macroblock: accept at edge 0, play the datapath, check timing and results.
   task automatic run_mb(input logic [9:0] x, input logic [9:0] y,
                         input logic [127:0] din, input logic [47:0] derr,
                         input logic [127:0] dout, input bit check_top,
                         input logic [31:0] exp_top, input logic [31:0] exp_left,
                         input int unsigned stall);
      int unsigned cyc;
      int unsigned done_cyc;
      done_cyc = (y != 10'd0) ? 15 : 13;
      chk("req_ready_idle", req_ready, 1'b1);
      req_x = x; req_y = y; req_in = din;
      req_q = 16'h1234; req_iq = 16'h5678;
      req_bias = 32'hA5A5_0001; req_zthresh = 32'h0000_0F0F;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      req_in = '0;
      cyc = 1;
      chk("dc_start_c1", dc_start, 1'b1);
      chk("busy_c1", busy, 1'b1);
      chk("dc_x", dc_x, x);
      chk("dc_y", dc_y, y);
      chk("dc_in", dc_in, din);
      chk("dc_bias", dc_bias, 32'hA5A5_0001);
      tick(); cyc = 2;
      chk("dc_start_c2", dc_start, 1'b0);
      tick(); cyc = 3;
      if (y != 10'd0) begin
         dc_top_derr_en = 1'b1;
         dc_top_derr_addr = x;
      end
      tick(); cyc = 4;
      dc_top_derr_en = 1'b0;
      if (check_top) chk("dc_top_derr", dc_top_derr, exp_top);
      while (cyc < done_cyc) begin
         tick();
         cyc++;
      end
      chk("res_valid_pre", res_valid, 1'b0);
      dc_done = 1'b1; dc_derr = derr; dc_out = dout;
      if (stall != 0) res_ready = 1'b0;
      tick();
      dc_done = 1'b0; dc_derr = '0; dc_out = '0;
      chk("res_valid_set", res_valid, 1'b1);
      chk("res_out", res_out, dout);
      chk("res_x", res_x, x);
      chk("res_y", res_y, y);
      for (int unsigned i = 0; i < stall; i++) begin
         chk("req_ready_stall", req_ready, 1'b0);
         chk("dc_start_stall", dc_start, 1'b0);
         req_x = 10'd7; req_valid = 1'b1;
         tick();
      end
      req_valid = 1'b0;
      res_ready = 1'b1;
      tick();
      chk("res_valid_clr", res_valid, 1'b0);
      chk("busy_done", busy, 1'b0);
      chk("dc_left_derr", dc_left_derr, exp_left);
      chk("req_ready_after", req_ready, 1'b1);
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_x = '0; req_y = '0; req_in = '0;
      req_q = '0; req_iq = '0; req_bias = '0; req_zthresh = '0;
      dc_top_derr_en = 1'b0; dc_top_derr_addr = '0;
      dc_out = '0; dc_derr = '0; dc_done = 1'b0;
      res_ready = 1'b1;
      #2;
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_dc_start", dc_start, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_left", dc_left_derr, 32'h0);
      chk("rst_top", dc_top_derr, 32'h0);
      chk("rst_res_out", res_out, 128'h0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // x=0,y=0: U(1,2,4) V(-1,0,-4); no read strobe, top stays 0.
      run_mb(10'd0, 10'd0, 128'h0001_0002_0003_0004_0005_0006_0007_0008,
             48'hFC00FF040201, 128'h1111_2222_3333_4444_5555_6666_7777_8888,
             1'b1, 32'h0, 32'hFDFF0301, 0);
      // x=3,y=0: U(4,-2,8) -> mem[3] U bytes (T0,T1)=(-2,2).
      run_mb(10'd3, 10'd0, 128'h0F, 48'h00000008FE04, 128'hABCD,
             1'b1, 32'h0, 32'h00000604, 0);
      // x=3,y=1: reads mem[3]; U e2=127 and V e2=-128 overflow cases.
      run_mb(10'd3, 10'd1, 128'hF0, 48'h8000007F007F, 128'hDEAD_BEEF,
             1'b1, 32'h000002FE, 32'hA0005F7F, 0);
      // x=0,y=1: reads mem[0]; V(-5,1,-7) -> left V bytes (-5,-6).
      run_mb(10'd0, 10'd1, 128'h1, 48'hF901FB000000, 128'h2,
             1'b1, 32'hFF000102, 32'hFAFB0000, 0);
      // x=1 continues the left chain; U(2,3,-1).
      chk("left_chain_hold", dc_left_derr, 32'hFAFB0000);
      run_mb(10'd1, 10'd0, 128'h3, 48'h000000FF0302, 128'h4,
             1'b1, 32'hFF000102, 32'h0000FF02, 0);

      // Reads while idle are still performed.
      dc_top_derr_en = 1'b1; dc_top_derr_addr = 10'd0; tick();
      chk("idle_rd0", dc_top_derr, 32'hFF010000);
      dc_top_derr_addr = 10'd1; tick();
      chk("idle_rd1", dc_top_derr, 32'h00000003);
      dc_top_derr_addr = 10'd3; tick();
      chk("idle_rd3", dc_top_derr, 32'hE0002000);
      dc_top_derr_en = 1'b0;

      // dc_done outside S_RUN is ignored.
      dc_done = 1'b1; dc_derr = '1; dc_out = '1; tick();
      dc_done = 1'b0; dc_derr = '0; dc_out = '0;
      chk("stray_done_valid", res_valid, 1'b0);
      chk("stray_done_busy", busy, 1'b0);
      tick();
      chk("stray_done_left", dc_left_derr, 32'h0000FF02);
      dc_top_derr_en = 1'b1; dc_top_derr_addr = 10'd1; tick();
      dc_top_derr_en = 1'b0;
      chk("stray_done_mem", dc_top_derr, 32'h00000003);

      // Result held for 20 cycles with res_ready low.
      run_mb(10'd2, 10'd0, 128'h5, 48'h0, 128'h6,
             1'b1, 32'h00000003, 32'h0, 20);
`ifdef DC_DERR_SCHED_STATS_EN
      chk("stat_stall", stat_stall_cnt, 32'd20);
      chk("stat_mb", stat_mb_cnt, 32'd6);
`endif
      // Accepted the cycle after res_valid clears. U(10,20,-128) V(-1,-2,127).
      run_mb(10'd5, 10'd0, 128'h7, 48'h7FFEFF80140A, 128'h8,
             1'b1, 32'h00000003, 32'h5FFFA00A, 0);

      // Reset asserted in cycle 8 of a run.
      req_x = 10'd6; req_y = 10'd0; req_in = 128'h99;
      req_valid = 1'b1; tick(); req_valid = 1'b0;
      for (int unsigned i = 1; i < 8; i++) tick();
      chk("mid_busy", busy, 1'b1);
      rst = 1'b1;
      #1;
      chk("mr_busy", busy, 1'b0);
      chk("mr_dc_start", dc_start, 1'b0);
      chk("mr_res_valid", res_valid, 1'b0);
      chk("mr_req_ready", req_ready, 1'b1);
      chk("mr_dc_x", dc_x, 10'd0);
      chk("mr_dc_in", dc_in, 128'h0);
      chk("mr_left", dc_left_derr, 32'h0);
      chk("mr_top", dc_top_derr, 32'h0);
      chk("mr_res_out", res_out, 128'h0);
      tick();
      rst = 1'b0;
      tick();
      // Normal run after reset: U(0,0,3) -> L1=2.
      run_mb(10'd6, 10'd0, 128'hAA, 48'h000000030000, 128'hBB,
             1'b1, 32'h0, 32'h00000200, 0);
`ifdef DC_DERR_SCHED_STATS_EN
      chk("stat_mb_post_rst", stat_mb_cnt, 32'd1);
      chk("stat_stall_post_rst", stat_stall_cnt, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/dc_derr_sched.md
# dc_derr_sched

Sequencer for the chroma DC error-diffusion quantizer. It accepts one macroblock request at a time in raster order and launches the DC-correction datapath. It serves that datapath's top-error read port from an internal per-column line buffer and its left-error input from a register. On completion it converts the returned diffusion errors into the next left/top error words and hands the quantized DC levels downstream through a one-entry valid/ready result buffer.

## Interface
- `MAX_MB_W`, 1024: line-buffer depth in macroblock columns. `MAX_MB_W` ≤ 1024.
- `ADDR_W`, 10: line-buffer address width, equal to clog2(`MAX_MB_W`).
- clk  in  1  single clock. All logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid / req_ready  in / out  1 / 1  request handshake.
- req_x, req_y  in  10 / 10  macroblock column / row.
- req_in  in  128  8 signed 16-bit DC coefficients: U in lanes 0–3, V in lanes 4–7.
- req_q, req_iq  in  16 / 16  quantizer step and inverse step.
- req_bias, req_zthresh  in  32 / 32  quantizer bias and zero threshold.
- dc_start  out  1  one-cycle launch pulse to the datapath.
- dc_x, dc_y, dc_in, dc_q, dc_iq, dc_bias, dc_zthresh  out  (as req_*)  registered copies of the request, held stable until dc_done.
- dc_left_derr, dc_top_derr  out  32 / 32  byte i = signed error term i. Bytes 0–1 are U, bytes 2–3 are V.
- dc_top_derr_en  in  1  line-buffer read strobe.
- dc_top_derr_addr  in  10  line-buffer read address (column).
- dc_out  in  128  quantized levels returned by the datapath.
- dc_derr  in  48  6 signed bytes: U e0,e1,e2 in bytes 0–2; V e0,e1,e2 in bytes 3–5.
- dc_done  in  1  one-cycle completion pulse.
- res_valid / res_ready  out / in  1 / 1  result handshake.
- res_out, res_x, res_y  out  128 / 10 / 10  captured levels and coordinates.
- busy  out  1  high whenever state ≠ S_IDLE.

## Operation
- States and transitions:
  - S_IDLE → S_LAUNCH on request accept.
  - S_LAUNCH → S_RUN, always. dc_start = 1 during S_LAUNCH only.
  - S_RUN → S_UPD on dc_done.
  - S_UPD → S_IDLE.
- Request accept rule:
  - req_ready = (state == S_IDLE) && !res_valid.
  - Acceptance occurs on the edge with req_valid && req_ready. All req_* fields are registered into dc_* on that edge.
- Line buffer: `MAX_MB_W` × 32 bits.
  - Read: when dc_top_derr_en is sampled high, dc_top_derr ← mem[dc_top_derr_addr[ADDR_W-1:0]] on the next edge. dc_top_derr holds until the next read.
- Error update: on the dc_done cycle, capture dc_derr and dc_out. For each channel c (U, V):
  - L0 = e0.
  - L1 = (3·e2) >>> 2, computed at 10 bits, arithmetic shift, then truncated to 8 bits.
  - T0 = e1.
  - T1 = (e2 − L1), truncated to 8 bits (wraps; no saturation).
- Writes in S_UPD:
  - dc_left_derr ← {L1v, L0v, L1u, L0u}.
  - mem[dc_x] ← {T1v, T0v, T1u, T0u}.
  - res_out/res_x/res_y are loaded and res_valid is set in the same cycle.
- Boundary handling:
  - x = 0 or y = 0: no clearing is needed. The datapath ignores left/top on those edges. Stale buffer contents are harmless.
  - dc_top_derr_en while state ≠ S_RUN: the read is performed anyway. There is no side effect.
  - dc_done outside S_RUN: ignored. No capture, no write.
  - Reset mid-operation: all state is discarded. The datapath is reset in the same domain.

## Timing
- Reset values:
  - req_ready = 1 (combinational).
  - dc_start, busy, res_valid = 0.
  - All dc_* data outputs, dc_left_derr, dc_top_derr, res_out, res_x, res_y = 0.
  - Line-buffer contents are undefined.
- Latency, with accept at edge 0:
  - dc_start is high in cycle 1.
  - y ≠ 0: read strobe in cycle 3; dc_done in cycle 15; res_valid in cycle 16.
  - y = 0: dc_done in cycle 13; res_valid in cycle 14.
- res_valid holds until res_ready. It clears on the handshake edge.
- The next request can be accepted the cycle after res_valid clears.
- Sustained throughput is one macroblock per 17 cycles (y ≠ 0) when res_ready is held high.

## Configuration
- `DC_DERR_SCHED_STATS_EN` defined: adds two outputs.
  - stat_mb_cnt (32): counts accepted requests.
  - stat_stall_cnt (32): counts cycles with res_valid && !res_ready.
  - Both reset to 0 and wrap at 2^32.
- Not defined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Request (x=0, y=0), res_ready = 1:
  - dc_start in cycle 1, no dc_top_derr_en, res_valid in cycle 14.
  - res_out equals dc_out captured at dc_done.
- Row 0 then row 1 at x=3, with derr U = (e0,e1,e2) = (4,−2,8) for the first request:
  - mem[3] = {…, T1u = 2, T0u = −2}.
  - In the second request dc_top_derr bytes 0–1 = (−2, 2) in the cycle after the read strobe.
- Left chain at x=1 after x=0 (V = (−5, 1, −7)):
  - dc_left_derr bytes 2–3 = (−5, −6). Check: (3·−7) >>> 2 = −6.
- Overflow: e2 = 127, L1 = 95, T1 = 32. e2 = −128: L1 = −96, T1 = −32.
- Hold res_ready = 0 for 20 cycles:
  - req_ready stays 0 and no dc_start is issued.
  - Accept occurs the cycle after res_ready rises.
  - With `DC_DERR_SCHED_STATS_EN`: stat_stall_cnt = 20.
- Assert rst in cycle 8 of a run:
  - All outputs return to their reset values immediately.
  - The next request completes normally.
